conva3_ctrl: RTL and testbench

Sequencing controller for the last LeNet5 convolution datapath (conva3_DP): two unitA_5 lanes, an adder, an accumulator with bias memory, and ReLU. On a start pulse it computes every output filter. For each filter it runs IFM_DEPTH/NUMBER_OF_UNITS passes; each pass loads weights, streams one IFM plane per lane, fires the convolution and accumulates. It asserts ReLU and an output write after the last pass, then raises done. It also owns the address-select muxes, so the RISC-V can load weights and biases only while the controller is idle.

---
 rtl/conva3_ctrl_pkg.sv | 36 +++
 rtl/conva3_ctrl_if.sv | 45 ++++
 rtl/conva3_ctrl_counter.sv | 37 +++
 rtl/conva3_ctrl.sv | 162 ++++++++++++++++
 tb/tb_conva3_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/conva3_ctrl_pkg.sv
// Shared constants and state encoding for the conva3 sequencing controller.
package conva3_ctrl_pkg;

  localparam int IFM_SIZE          = 5;
  localparam int IFM_DEPTH         = 16;
  localparam int KERNAL_SIZE       = 5;
  localparam int NUMBER_OF_FILTERS = 120;
  localparam int NUMBER_OF_UNITS   = 2;
  localparam int CONV_LATENCY      = 1;

  localparam int NUM_PASSES      = IFM_DEPTH / NUMBER_OF_UNITS;
  localparam int NUM_WM          = KERNAL_SIZE * KERNAL_SIZE;
  localparam int NUM_PIX         = IFM_SIZE * IFM_SIZE;
  localparam int ADDRESS_SIZE_WM = $clog2(NUM_WM * NUMBER_OF_FILTERS * NUM_PASSES);
  localparam int FILT_W          = $clog2(NUMBER_OF_FILTERS);
  localparam int PIX_W           = $clog2(NUM_PIX);
  localparam int PASS_W          = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

  // One counter serves both the weight-tap and pixel phases, so size it for the longer one.
  localparam int TAP_MAX = ((NUM_WM > NUM_PIX) ? NUM_WM : NUM_PIX) - 1;
  localparam int TAP_W   = $clog2(TAP_MAX + 1);
  localparam int WAIT_W  = $clog2(CONV_LATENCY + 2);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_WLOAD  = 4'd1,
    ST_STREAM = 4'd2,
    ST_SETTLE = 4'd3,
    ST_CONV   = 4'd4,
    ST_WAIT   = 4'd5,
    ST_ACCU   = 4'd6,
    ST_RELU   = 4'd7,
    ST_DONE   = 4'd8
  } state_e;

endpackage

// File: rtl/conva3_ctrl_if.sv
// Control bundle between the conva3 controller (master) and the datapath/host side (slave).
interface conva3_ctrl_if;
  import conva3_ctrl_pkg::*;

  logic                       start;
  logic                       busy;
  logic                       done;
  logic                       wm_addr_sel;
  logic                       wm_enable_read;
  logic [ADDRESS_SIZE_WM-1:0] wm_address_read_current;
  logic                       wm_fifo_enable;
  logic                       bm_addr_sel;
  logic                       bm_enable_read;
  logic [FILT_W-1:0]          bm_address_read_current;
  logic                       ifm_enable_read;
  logic [PIX_W-1:0]           ifm_address_read_current;
  logic [PASS_W-1:0]          ifm_sel;
  logic                       fifo_enable;
  logic                       conv_enable;
  logic                       accu_enable;
  logic                       relu_enable;
  logic                       ofm_enable_write;
  logic [FILT_W-1:0]          ofm_address;
  state_e                     dbg_state;

  // start is a one-cycle pulse with no ready: it is taken only when the controller is idle.
  modport master (
    input  start,
    output busy, done, wm_addr_sel, wm_enable_read, wm_address_read_current,
           wm_fifo_enable, bm_addr_sel, bm_enable_read, bm_address_read_current,
           ifm_enable_read, ifm_address_read_current, ifm_sel, fifo_enable,
           conv_enable, accu_enable, relu_enable, ofm_enable_write, ofm_address,
           dbg_state
  );

  modport slave (
    output start,
    input  busy, done, wm_addr_sel, wm_enable_read, wm_address_read_current,
           wm_fifo_enable, bm_addr_sel, bm_enable_read, bm_address_read_current,
           ifm_enable_read, ifm_address_read_current, ifm_sel, fifo_enable,
           conv_enable, accu_enable, relu_enable, ofm_enable_write, ofm_address,
           dbg_state
  );

endinterface

// File: rtl/conva3_ctrl_counter.sv
// Up-counter that wraps to zero after MAX; clr has priority over inc.
module conva3_ctrl_counter #(
  parameter int unsigned MAX = 1,
  parameter int          W   = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = (count_q == MAX_V) ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/conva3_ctrl.sv
// Sequencer for the conva3 datapath: per filter, NUM_PASSES rounds of weight load,
// plane stream, convolve and accumulate, then ReLU plus output write.
module conva3_ctrl
  import conva3_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  conva3_ctrl_if.master bus
);

  localparam logic [TAP_W-1:0]  TAP_WM_LAST  = TAP_W'(NUM_WM - 1);
  localparam logic [TAP_W-1:0]  TAP_PIX_LAST = TAP_W'(NUM_PIX - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST    = WAIT_W'(CONV_LATENCY);
  localparam logic [PASS_W-1:0] PASS_LAST    = PASS_W'(NUM_PASSES - 1);
  localparam logic [FILT_W-1:0] FILT_LAST    = FILT_W'(NUMBER_OF_FILTERS - 1);

  state_e                     state_q, state_d;
  logic [ADDRESS_SIZE_WM-1:0] wm_addr_q, wm_addr_d;
  logic                       busy_q, done_q;
  logic                       wm_enable_read_q, wm_fifo_enable_q;
  logic                       ifm_enable_read_q, fifo_enable_q;
  logic                       conv_enable_q, accu_enable_q, relu_enable_q;

  logic              tap_inc, tap_clr, wait_inc;
  logic              pass_inc, pass_clr, filt_inc, filt_clr;
  logic [TAP_W-1:0]  tap_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [PASS_W-1:0] pass_cnt;
  logic [FILT_W-1:0] filt_cnt;

  conva3_ctrl_counter #(.MAX(TAP_MAX), .W(TAP_W)) u_tap_cnt (
    .clk(clk), .reset(reset), .clr(tap_clr), .inc(tap_inc), .count(tap_cnt)
  );

  conva3_ctrl_counter #(.MAX(CONV_LATENCY), .W(WAIT_W)) u_wait_cnt (
    .clk(clk), .reset(reset), .clr(1'b0), .inc(wait_inc), .count(wait_cnt)
  );

  conva3_ctrl_counter #(.MAX(NUM_PASSES - 1), .W(PASS_W)) u_pass_cnt (
    .clk(clk), .reset(reset), .clr(pass_clr), .inc(pass_inc), .count(pass_cnt)
  );

  conva3_ctrl_counter #(.MAX(NUMBER_OF_FILTERS - 1), .W(FILT_W)) u_filt_cnt (
    .clk(clk), .reset(reset), .clr(filt_clr), .inc(filt_inc), .count(filt_cnt)
  );

  always_comb begin
    state_d   = state_q;
    wm_addr_d = wm_addr_q;
    tap_inc   = 1'b0;
    tap_clr   = 1'b0;
    wait_inc  = 1'b0;
    pass_inc  = 1'b0;
    pass_clr  = 1'b0;
    filt_inc  = 1'b0;
    filt_clr  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_WLOAD;
          wm_addr_d = '0;
          pass_clr  = 1'b1;
          filt_clr  = 1'b1;
        end
      end
      ST_WLOAD: begin
        // Weight address runs linearly over the whole job and is never rewound per pass.
        tap_inc   = 1'b1;
        wm_addr_d = wm_addr_q + ADDRESS_SIZE_WM'(1);
        if (tap_cnt == TAP_WM_LAST) begin
          tap_clr = 1'b1;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        tap_inc = 1'b1;
        if (tap_cnt == TAP_PIX_LAST) begin
          tap_clr = 1'b1;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: state_d = ST_CONV;
      ST_CONV:   state_d = ST_WAIT;
      ST_WAIT: begin
        wait_inc = 1'b1;
        if (wait_cnt == WAIT_LAST) state_d = ST_ACCU;
      end
      ST_ACCU: begin
        if (pass_cnt == PASS_LAST) begin
          state_d = ST_RELU;
        end else begin
          pass_inc = 1'b1;
          state_d  = ST_WLOAD;
        end
      end
      ST_RELU: begin
        pass_clr = 1'b1;
        if (filt_cnt == FILT_LAST) begin
          state_d = ST_DONE;
        end else begin
          filt_inc = 1'b1;
          state_d  = ST_WLOAD;
        end
      end
      ST_DONE: begin
        filt_clr = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      wm_addr_q         <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      wm_enable_read_q  <= 1'b0;
      wm_fifo_enable_q  <= 1'b0;
      ifm_enable_read_q <= 1'b0;
      fifo_enable_q     <= 1'b0;
      conv_enable_q     <= 1'b0;
      accu_enable_q     <= 1'b0;
      relu_enable_q     <= 1'b0;
    end else begin
      state_q           <= state_d;
      wm_addr_q         <= wm_addr_d;
      busy_q            <= (state_d != ST_IDLE);
      done_q            <= (state_d == ST_DONE);
      wm_enable_read_q  <= (state_d == ST_WLOAD);
      ifm_enable_read_q <= (state_d == ST_STREAM);
      conv_enable_q     <= (state_d == ST_CONV);
      accu_enable_q     <= (state_d == ST_ACCU);
      relu_enable_q     <= (state_d == ST_RELU);
      wm_fifo_enable_q  <= wm_enable_read_q;
      fifo_enable_q     <= ifm_enable_read_q;
    end
  end

  assign bus.busy                     = busy_q;
  assign bus.done                     = done_q;
  assign bus.wm_addr_sel              = busy_q;
  assign bus.wm_enable_read           = wm_enable_read_q;
  assign bus.wm_address_read_current  = wm_addr_q;
  assign bus.wm_fifo_enable           = wm_fifo_enable_q;
  assign bus.bm_addr_sel              = busy_q;
  assign bus.bm_enable_read           = busy_q;
  assign bus.bm_address_read_current  = filt_cnt;
  assign bus.ifm_enable_read          = ifm_enable_read_q;
  assign bus.ifm_address_read_current = tap_cnt[PIX_W-1:0];
  assign bus.ifm_sel                  = pass_cnt;
  assign bus.fifo_enable              = fifo_enable_q;
  assign bus.conv_enable              = conv_enable_q;
  assign bus.accu_enable              = accu_enable_q;
  assign bus.relu_enable              = relu_enable_q;
  assign bus.ofm_enable_write         = relu_enable_q;
  assign bus.ofm_address              = filt_cnt;
  assign bus.dbg_state                = state_q;

endmodule

// File: tb/tb_conva3_ctrl.sv
// Directed bench for conva3_ctrl: reset, first-pass timing, full run, ignored start, abort and restart.
module tb_conva3_ctrl;
  import conva3_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  conva3_ctrl_if bus ();

  conva3_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] flags();
    return {bus.busy, bus.done, bus.wm_addr_sel, bus.wm_enable_read, bus.wm_fifo_enable,
            bus.bm_addr_sel, bus.bm_enable_read, bus.ifm_enable_read, bus.fifo_enable,
            bus.conv_enable, bus.accu_enable, bus.relu_enable, bus.ofm_enable_write};
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_flags"},   32'(flags()), 32'd0);
    check({tag, "_wm_addr"}, 32'(bus.wm_address_read_current), 32'd0);
    check({tag, "_bm_addr"}, 32'(bus.bm_address_read_current), 32'd0);
    check({tag, "_ifm_addr"}, 32'(bus.ifm_address_read_current), 32'd0);
    check({tag, "_ifm_sel"}, 32'(bus.ifm_sel), 32'd0);
    check({tag, "_ofm_addr"}, 32'(bus.ofm_address), 32'd0);
    check({tag, "_state"},   32'(bus.dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    int cyc;
    int done_cyc;
    int done_seen;
    int ofm_cnt, accu_cnt, conv_cnt, wm_rd_cnt, ifm_rd_cnt, busy_low;
    int abort_done;

    cyc = 0; done_cyc = 0; done_seen = 0;
    ofm_cnt = 0; accu_cnt = 0; conv_cnt = 0; wm_rd_cnt = 0; ifm_rd_cnt = 0; busy_low = 0;
    abort_done = 0;

    // Reset held three cycles; start raised alongside reset must be ignored.
    reset     = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    check_idle("reset");
    step();

    // Full run; cycle T+1 is the first sample after the edge that takes start.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    cyc = 1;
    while (done_seen == 0 && cyc <= 53000) begin
      case (cyc)
        1: begin
          check("c1_wm_en", 32'(bus.wm_enable_read), 32'd1);
          check("c1_wm_addr", 32'(bus.wm_address_read_current), 32'd0);
          check("c1_busy", 32'(bus.busy), 32'd1);
          check("c1_wm_sel", 32'(bus.wm_addr_sel), 32'd1);
          check("c1_bm_sel", 32'(bus.bm_addr_sel), 32'd1);
          check("c1_bm_en", 32'(bus.bm_enable_read), 32'd1);
          check("c1_bm_addr", 32'(bus.bm_address_read_current), 32'd0);
          check("c1_wm_fifo", 32'(bus.wm_fifo_enable), 32'd0);
        end
        2:  check("c2_wm_fifo", 32'(bus.wm_fifo_enable), 32'd1);
        25: begin
          check("c25_wm_en", 32'(bus.wm_enable_read), 32'd1);
          check("c25_wm_addr", 32'(bus.wm_address_read_current), 32'd24);
          check("c25_ifm_en", 32'(bus.ifm_enable_read), 32'd0);
        end
        26: begin
          check("c26_wm_en", 32'(bus.wm_enable_read), 32'd0);
          check("c26_wm_fifo", 32'(bus.wm_fifo_enable), 32'd1);
          check("c26_ifm_en", 32'(bus.ifm_enable_read), 32'd1);
          check("c26_ifm_addr", 32'(bus.ifm_address_read_current), 32'd0);
          check("c26_ifm_sel", 32'(bus.ifm_sel), 32'd0);
          check("c26_fifo", 32'(bus.fifo_enable), 32'd0);
        end
        27: begin
          check("c27_wm_fifo", 32'(bus.wm_fifo_enable), 32'd0);
          check("c27_fifo", 32'(bus.fifo_enable), 32'd1);
        end
        50: begin
          check("c50_ifm_en", 32'(bus.ifm_enable_read), 32'd1);
          check("c50_ifm_addr", 32'(bus.ifm_address_read_current), 32'd24);
        end
        51: begin
          check("c51_ifm_en", 32'(bus.ifm_enable_read), 32'd0);
          check("c51_fifo", 32'(bus.fifo_enable), 32'd1);
          check("c51_conv", 32'(bus.conv_enable), 32'd0);
        end
        52: begin
          check("c52_conv", 32'(bus.conv_enable), 32'd1);
          check("c52_fifo", 32'(bus.fifo_enable), 32'd0);
        end
        54: check("c54_accu", 32'(bus.accu_enable), 32'd0);
        55: begin
          check("c55_accu", 32'(bus.accu_enable), 32'd1);
          check("c55_conv", 32'(bus.conv_enable), 32'd0);
        end
        56: begin
          check("c56_wm_en", 32'(bus.wm_enable_read), 32'd1);
          check("c56_wm_addr", 32'(bus.wm_address_read_current), 32'd25);
          check("c56_ifm_sel", 32'(bus.ifm_sel), 32'd1);
        end
        default: ;
      endcase

      if (bus.wm_enable_read) wm_rd_cnt++;
      if (bus.ifm_enable_read) ifm_rd_cnt++;
      if (bus.conv_enable) conv_cnt++;
      if (!bus.busy) busy_low++;
      if (bus.accu_enable) begin
        check("ifm_sel_at_accu", 32'(bus.ifm_sel), 32'(accu_cnt % NUM_PASSES));
        accu_cnt++;
      end
      if (bus.ofm_enable_write) begin
        check("ofm_addr", 32'(bus.ofm_address), 32'(ofm_cnt));
        check("bm_addr_at_relu", 32'(bus.bm_address_read_current), 32'(ofm_cnt));
        check("relu_with_write", 32'(bus.relu_enable), 32'd1);
        ofm_cnt++;
      end

      if (bus.done) begin
        done_seen = 1;
        done_cyc  = cyc;
      end else begin
        if (cyc == 100) bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc++;
      end
    end

    check("done_cycle", 32'(done_cyc), 32'd52921);
    check("ofm_writes", 32'(ofm_cnt), 32'd120);
    check("accu_pulses", 32'(accu_cnt), 32'd960);
    check("conv_pulses", 32'(conv_cnt), 32'd960);
    check("wm_reads", 32'(wm_rd_cnt), 32'd24000);
    check("ifm_reads", 32'(ifm_rd_cnt), 32'd24000);
    check("busy_gaps", 32'(busy_low), 32'd0);
    check("final_wm_addr", 32'(bus.wm_address_read_current), 32'd24000);
    check("busy_at_done", 32'(bus.busy), 32'd1);
    step();
    check("post_done_busy", 32'(bus.busy), 32'd0);
    check("post_done_pulse", 32'(bus.done), 32'd0);
    check("post_done_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    step();

    // Second run aborted by reset at T+1000 (filter 2, pass 2, tap 7).
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 1000) begin
      if (bus.done) abort_done++;
      step();
      cyc++;
    end
    check("c1000_busy", 32'(bus.busy), 32'd1);
    check("c1000_wm_en", 32'(bus.wm_enable_read), 32'd1);
    check("c1000_wm_addr", 32'(bus.wm_address_read_current), 32'd457);
    check("c1000_bm_addr", 32'(bus.bm_address_read_current), 32'd2);
    check("c1000_ifm_sel", 32'(bus.ifm_sel), 32'd2);
    reset = 1'b1;
    step();
    check_idle("abort");
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.done) abort_done++;
    end
    check("abort_no_done", 32'(abort_done), 32'd0);
    check_idle("post_abort");

    // Restart after abort begins from weight address 0.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("restart_busy", 32'(bus.busy), 32'd1);
    check("restart_wm_en", 32'(bus.wm_enable_read), 32'd1);
    check("restart_wm_addr", 32'(bus.wm_address_read_current), 32'd0);
    check("restart_bm_addr", 32'(bus.bm_address_read_current), 32'd0);
    check("restart_ifm_sel", 32'(bus.ifm_sel), 32'd0);
    for (int i = 0; i < 24; i++) step();
    check("restart_c25_wm_addr", 32'(bus.wm_address_read_current), 32'd24);
    step();
    check("restart_c26_ifm_en", 32'(bus.ifm_enable_read), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
